// File: rtl/second_game_obstacle_field.sv
// rtl/second_game_obstacle_field.sv - scrolling obstacle rows with pixel lookup, collision and score
// Rows live in a ring buffer indexed from head; the pixel lookup folds y by the current scroll offset.
module second_game_obstacle_field #(
  parameter int SECOND_GAME_SCREEN_WIDTH  = 400,
  parameter int SECOND_GAME_SCREEN_HEIGHT = 600,
  parameter int SECOND_GAME_PLAYER_SIZE   = 20,
  parameter int NUM_ROWS                  = 4,
  parameter int ROW_PITCH                 = 150,
  parameter int ROW_HEIGHT                = 20,
  parameter int GAP_WIDTH                 = 80,
  parameter int SCROLL_SPEED              = 2,
  localparam int XW = $clog2(SECOND_GAME_SCREEN_WIDTH),
  localparam int YW = $clog2(SECOND_GAME_SCREEN_HEIGHT)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_frame_tick,
  input  logic          i_restart,
  input  logic          i_disp_enbl,
  input  logic [XW-1:0] i_screen_x,
  input  logic [YW-1:0] i_screen_y,
  input  logic [XW-1:0] i_player_x,
  output logic          o_is_obstacle,
  output logic          o_collision,
  output logic [15:0]   o_score
);

  localparam int HW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int OW  = $clog2(ROW_PITCH);
  localparam int YW1 = YW + 1;
  localparam int OW1 = OW + 1;
  localparam int HW1 = HW + 1;
  localparam int CW  = ((XW > 9) ? XW : 9) + 1;

  localparam logic [YW1-1:0]    C_HEIGHT = YW1'(SECOND_GAME_SCREEN_HEIGHT);
  localparam logic [YW1-1:0]    C_ROW_H  = YW1'(ROW_HEIGHT);
  localparam logic [OW1-1:0]    C_PITCH  = OW1'(ROW_PITCH);
  localparam logic [OW1-1:0]    C_SPEED  = OW1'(SCROLL_SPEED);
  localparam logic [8:0]        C_SPAN   = 9'(SECOND_GAME_SCREEN_WIDTH - GAP_WIDTH);
  localparam logic [CW-1:0]     C_GAP_W  = CW'(GAP_WIDTH);
  localparam logic [HW1-1:0]    C_NROWS  = HW1'(NUM_ROWS);
  localparam logic [HW-1:0]     C_LAST   = HW'(NUM_ROWS - 1);
  localparam logic signed [10:0] C_SIZE  = 11'(SECOND_GAME_PLAYER_SIZE);
  localparam logic signed [10:0] C_Y_LO  = 11'(SECOND_GAME_PLAYER_SIZE / 2 - SECOND_GAME_PLAYER_SIZE);
  localparam logic signed [10:0] C_Y_HI  = 11'(SECOND_GAME_PLAYER_SIZE / 2 + SECOND_GAME_PLAYER_SIZE);

  logic [OW-1:0]       r_offset;
  logic [HW-1:0]       r_head;
  logic [NUM_ROWS-1:0] r_valid;
  logic [8:0]          r_gap [NUM_ROWS];
  logic [15:0]         r_lfsr;
  logic                r_collision;
  logic [15:0]         r_score;

  logic                w_lfsr_fb;
  logic [8:0]          w_g;
  logic [8:0]          w_gap_new;
  logic [YW1-1:0]      w_y_sum;
  logic [YW1-1:0]      w_y_rel;
  logic [YW1-1:0]      w_within;
  logic [HW-1:0]       w_slot;
  logic [HW1-1:0]      w_idx_sum;
  logic [HW-1:0]       w_idx;
  logic                w_row_valid;
  logic [8:0]          w_gap_sel;
  logic [CW-1:0]       w_x;
  logic [CW-1:0]       w_gap_lo;
  logic [CW-1:0]       w_gap_hi;
  logic                w_outside_gap;
  logic                w_in_row;
  logic signed [10:0]  w_px;
  logic signed [10:0]  w_sx;
  logic signed [10:0]  w_sy;
  logic                w_hit;
  logic [OW1-1:0]      w_n;
  logic                w_wrap;
  logic [HW-1:0]       w_head_next;

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  // Fold the 9-bit LFSR sample into the legal gap range with a single subtract.
  assign w_g       = r_lfsr[8:0];
  assign w_gap_new = (w_g > C_SPAN) ? (w_g - C_SPAN) : w_g;

  assign w_y_sum = YW1'(i_screen_y) + YW1'(r_offset);
  assign w_y_rel = (w_y_sum >= C_HEIGHT) ? (w_y_sum - C_HEIGHT) : w_y_sum;

  always_comb begin
    w_slot   = '0;
    w_within = w_y_rel;
    for (int s = 1; s < NUM_ROWS; s++) begin
      if (w_y_rel >= YW1'(s * ROW_PITCH)) begin
        w_slot   = HW'(s);
        w_within = w_y_rel - YW1'(s * ROW_PITCH);
      end
    end
  end

  assign w_idx_sum = HW1'(r_head) + HW1'(w_slot);
  assign w_idx     = (w_idx_sum >= C_NROWS) ? HW'(w_idx_sum - C_NROWS) : HW'(w_idx_sum);

  assign w_row_valid   = r_valid[w_idx];
  assign w_gap_sel     = r_gap[w_idx];
  assign w_x           = CW'(i_screen_x);
  assign w_gap_lo      = CW'(w_gap_sel);
  assign w_gap_hi      = w_gap_lo + C_GAP_W;
  assign w_outside_gap = (w_x < w_gap_lo) || (w_x >= w_gap_hi);
  assign w_in_row      = (w_within < C_ROW_H);
  assign o_is_obstacle = w_row_valid && w_in_row && w_outside_gap;

  // Player box test in signed arithmetic so boxes near the left edge go negative cleanly.
  assign w_px  = 11'(i_player_x);
  assign w_sx  = 11'(i_screen_x);
  assign w_sy  = 11'(i_screen_y);
  assign w_hit = i_disp_enbl && o_is_obstacle
              && (w_sx >= w_px - C_SIZE) && (w_sx <= w_px + C_SIZE)
              && (w_sy >= C_Y_LO) && (w_sy <= C_Y_HI);

  assign w_n         = OW1'(r_offset) + C_SPEED;
  assign w_wrap      = (w_n >= C_PITCH);
  assign w_head_next = (r_head == C_LAST) ? '0 : r_head + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_offset    <= '0;
      r_head      <= '0;
      r_valid     <= '0;
      r_lfsr      <= 16'hACE1;
      r_collision <= 1'b0;
      r_score     <= '0;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
      if (i_restart) begin
        r_offset    <= '0;
        r_head      <= '0;
        r_valid     <= '0;
        r_collision <= 1'b0;
        r_score     <= '0;
      end else begin
        if (w_hit) begin
          r_collision <= 1'b1;
        end
        if (i_frame_tick && !r_collision) begin
          if (!w_wrap) begin
            r_offset <= OW'(w_n);
          end else begin
            // The slot being written becomes the bottom row as head advances past it.
            r_offset        <= OW'(w_n - C_PITCH);
            r_valid[r_head] <= 1'b1;
            r_gap[r_head]   <= w_gap_new;
            r_head          <= w_head_next;
            if (r_score != 16'hFFFF) begin
              r_score <= r_score + 16'd1;
            end
          end
        end
      end
    end
  end

  assign o_collision = r_collision;
  assign o_score     = r_score;

endmodule

// File: tb/tb_second_game_obstacle_field.sv
// tb/tb_second_game_obstacle_field.sv - self-checking bench with a row-queue reference model
module tb_second_game_obstacle_field;

  localparam int W  = 400;
  localparam int H  = 600;
  localparam int PS = 20;
  localparam int NR = 4;
  localparam int RP = 150;
  localparam int RH = 20;
  localparam int GW = 80;
  localparam int SS = 2;

  logic        clk     = 1'b0;
  logic        clk_run = 1'b1;
  logic        rst     = 1'b1;
  logic        tick    = 1'b0;
  logic        restart = 1'b0;
  logic        disp    = 1'b0;
  logic [8:0]  sx      = '0;
  logic [9:0]  sy      = '0;
  logic [8:0]  px      = '0;
  logic        o_obs;
  logic        o_coll;
  logic [15:0] o_score;

  int checks = 0;
  int errors = 0;

  // Reference model: rows held top-to-bottom, shifted up when a new row enters at the bottom.
  int          m_offset;
  int          m_score;
  bit          m_valid [NR];
  int          m_gap [NR];
  bit          m_coll;
  logic [15:0] m_lfsr;
  logic [15:0] mo_lfsr;
  bit          mo_coll;
  bit          mo_hit;
  int          xc;

  second_game_obstacle_field dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_frame_tick (tick),
    .i_restart    (restart),
    .i_disp_enbl  (disp),
    .i_screen_x   (sx),
    .i_screen_y   (sy),
    .i_player_x   (px),
    .o_is_obstacle(o_obs),
    .o_collision  (o_coll),
    .o_score      (o_score)
  );

  always #5 if (clk_run) clk = ~clk;

  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
  endfunction

  function automatic int gap_of(input logic [15:0] l);
    int g = int'(l[8:0]);
    return (g > W - GW) ? g - (W - GW) : g;
  endfunction

  function automatic bit m_obst(input int x, input int y);
    int yr = (y + m_offset) % H;
    int s  = yr / RP;
    int w  = yr % RP;
    return m_valid[s] && (w < RH) && ((x < m_gap[s]) || (x >= m_gap[s] + GW));
  endfunction

  function automatic bit in_box(input int x, input int y, input int p);
    return (x >= p - PS) && (x <= p + PS) && (y >= PS / 2 - PS) && (y <= PS / 2 + PS);
  endfunction

  task automatic model_clear();
    m_offset = 0;
    m_score  = 0;
    m_coll   = 1'b0;
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0;
      m_gap[i]   = 0;
    end
  endtask

  always @(posedge clk) begin
    mo_lfsr = m_lfsr;
    mo_coll = m_coll;
    mo_hit  = disp && m_obst(int'(sx), int'(sy)) && in_box(int'(sx), int'(sy), int'(px));
    if (rst) begin
      model_clear();
      m_lfsr = 16'hACE1;
    end else begin
      m_lfsr = lfsr_next(mo_lfsr);
      if (restart) begin
        model_clear();
      end else begin
        if (mo_hit) m_coll = 1'b1;
        if (tick && !mo_coll) begin
          m_offset = m_offset + SS;
          if (m_offset >= RP) begin
            m_offset = m_offset - RP;
            for (int i = 0; i < NR - 1; i++) begin
              m_valid[i] = m_valid[i + 1];
              m_gap[i]   = m_gap[i + 1];
            end
            m_valid[NR - 1] = 1'b1;
            m_gap[NR - 1]   = gap_of(mo_lfsr);
            if (m_score < 65535) m_score = m_score + 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full-screen lookup against the model with the clock held so the state cannot move.
  task automatic scan_full(output int bad);
    bad = 0;
    @(negedge clk);
    clk_run = 1'b0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        sx = 9'(x);
        sy = 10'(y);
        #1;
        if (o_obs !== m_obst(x, y)) bad++;
      end
    end
    sx = '0;
    sy = '0;
    clk_run = 1'b1;
    step();
  endtask

  task automatic test_reset();
    int bad;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++;
    if (o_coll !== 1'b0) begin
      errors++;
      $display("FAIL reset_collision: got %0b expected 0", o_coll);
    end
    checks++;
    if (o_score !== 16'd0) begin
      errors++;
      $display("FAIL reset_score: got %0d expected 0", o_score);
    end
    scan_full(bad);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL reset_scan: got %0d obstacle pixels expected 0", bad);
    end
  endtask

  task automatic test_scroll();
    int g, bad;
    bit e;
    tick = 1'b1;
    repeat (75) step();
    tick = 1'b0;
    checks++;
    if (o_score !== 16'd1) begin
      errors++;
      $display("FAIL scroll_score: got %0d expected 1", o_score);
    end
    g   = m_gap[NR - 1];
    bad = 0;
    sx  = '0;
    for (int y = 440; y < 480; y++) begin
      sy = 10'(y);
      #1;
      e = (y >= 450) && (y < 470) && (g != 0);
      if (o_obs !== e) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL scroll_column: got %0d wrong pixels expected 0 (gap %0d)", bad, g);
    end
    sy = 10'd455;
    sx = 9'(g);
    #1;
    checks++;
    if (o_obs !== 1'b0) begin
      errors++;
      $display("FAIL scroll_gap_start: got %0b expected 0 at x=%0d", o_obs, g);
    end
    if (g + GW < W) begin
      sx = 9'(g + GW);
      #1;
      checks++;
      if (o_obs !== 1'b1) begin
        errors++;
        $display("FAIL scroll_gap_end: got %0b expected 1 at x=%0d", o_obs, g + GW);
      end
    end
    sx = '0;
    sy = '0;
  endtask

  task automatic test_gap_fold();
    int tg [4] = '{320, 321, 511, 0};
    int ex [4] = '{320, 1, 191, 0};
    int n, e;
    foreach (tg[k]) begin
      restart = 1'b1;
      step();
      restart = 1'b0;
      tick = 1'b1;
      repeat (74) step();
      tick = 1'b0;
      n = 0;
      while ((m_lfsr[8:0] != 9'(tg[k])) && (n < 20000)) begin
        step();
        n++;
      end
      if (n >= 20000) begin
        checks++;
        errors++;
        $display("FAIL gap_wait_%0d: got no lfsr match expected one within 20000 cycles", tg[k]);
        continue;
      end
      tick = 1'b1;
      step();
      tick = 1'b0;
      e  = ex[k];
      sy = 10'd455;
      checks++;
      if (o_score !== 16'd1) begin
        errors++;
        $display("FAIL gap_score_%0d: got %0d expected 1", tg[k], o_score);
      end
      if (e > 0) begin
        sx = 9'(e - 1);
        #1;
        checks++;
        if (o_obs !== 1'b1) begin
          errors++;
          $display("FAIL gap_left_%0d: got %0b expected 1", tg[k], o_obs);
        end
      end
      sx = 9'(e);
      #1;
      checks++;
      if (o_obs !== 1'b0) begin
        errors++;
        $display("FAIL gap_first_%0d: got %0b expected 0", tg[k], o_obs);
      end
      if (e + GW - 1 < W) begin
        sx = 9'(e + GW - 1);
        #1;
        checks++;
        if (o_obs !== 1'b0) begin
          errors++;
          $display("FAIL gap_last_%0d: got %0b expected 0", tg[k], o_obs);
        end
      end
      if (e + GW < W) begin
        sx = 9'(e + GW);
        #1;
        checks++;
        if (o_obs !== 1'b1) begin
          errors++;
          $display("FAIL gap_right_%0d: got %0b expected 1", tg[k], o_obs);
        end
      end
    end
    sx = '0;
    sy = '0;
  endtask

  task automatic test_wrap();
    int bad;
    restart = 1'b1;
    step();
    restart = 1'b0;
    tick = 1'b1;
    repeat (300) step();
    tick = 1'b0;
    checks++;
    if (o_score !== 16'd4) begin
      errors++;
      $display("FAIL wrap_score: got %0d expected 4", o_score);
    end
    scan_full(bad);
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL wrap_scan: got %0d wrong pixels expected 0", bad);
    end
  endtask

  task automatic test_no_disp();
    xc = ((m_gap[0] <= 100) && (100 < m_gap[0] + GW)) ? 300 : 100;
    sx = 9'(xc);
    px = 9'(xc);
    sy = 10'd5;
    disp = 1'b0;
    #1;
    checks++;
    if (o_obs !== 1'b1) begin
      errors++;
      $display("FAIL nodisp_pixel: got %0b expected 1 at x=%0d", o_obs, xc);
    end
    step();
    step();
    checks++;
    if (o_coll !== 1'b0) begin
      errors++;
      $display("FAIL nodisp_collision: got %0b expected 0", o_coll);
    end
  endtask

  task automatic test_collision();
    disp = 1'b1;
    step();
    disp = 1'b0;
    checks++;
    if (o_coll !== 1'b1) begin
      errors++;
      $display("FAIL collision_set: got %0b expected 1", o_coll);
    end
    tick = 1'b1;
    repeat (200) step();
    tick = 1'b0;
    checks++;
    if (o_score !== 16'd4) begin
      errors++;
      $display("FAIL collision_score_frozen: got %0d expected 4", o_score);
    end
    checks++;
    if (o_coll !== 1'b1) begin
      errors++;
      $display("FAIL collision_sticky: got %0b expected 1", o_coll);
    end
    sx = 9'(xc);
    sy = 10'd19;
    #1;
    checks++;
    if (o_obs !== 1'b1) begin
      errors++;
      $display("FAIL collision_offset_y19: got %0b expected 1", o_obs);
    end
    sy = 10'd20;
    #1;
    checks++;
    if (o_obs !== 1'b0) begin
      errors++;
      $display("FAIL collision_offset_y20: got %0b expected 0", o_obs);
    end
  endtask

  task automatic test_restart_tick();
    int bad;
    restart = 1'b1;
    tick = 1'b1;
    step();
    restart = 1'b0;
    tick = 1'b0;
    checks++;
    if (o_coll !== 1'b0) begin
      errors++;
      $display("FAIL restart_collision: got %0b expected 0", o_coll);
    end
    checks++;
    if (o_score !== 16'd0) begin
      errors++;
      $display("FAIL restart_score: got %0d expected 0", o_score);
    end
    bad = 0;
    sx = 9'(xc);
    for (int y = 0; y < H; y++) begin
      sy = 10'(y);
      #1;
      if (o_obs !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL restart_rows_invalid: got %0d obstacle pixels expected 0", bad);
    end
    tick = 1'b1;
    repeat (74) step();
    tick = 1'b0;
    checks++;
    if (o_score !== 16'd0) begin
      errors++;
      $display("FAIL restart_tick_dropped: got %0d expected 0", o_score);
    end
    tick = 1'b1;
    step();
    tick = 1'b0;
    checks++;
    if (o_score !== 16'd1) begin
      errors++;
      $display("FAIL restart_first_wrap: got %0d expected 1", o_score);
    end
    sx = '0;
    sy = '0;
  endtask

  task automatic test_random();
    int t;
    restart = 1'b1;
    step();
    restart = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick    = ($urandom_range(0, 2) == 0);
      restart = ($urandom_range(0, 399) == 0);
      disp    = 1'($urandom_range(0, 1));
      px      = 9'($urandom_range(0, W - 1));
      if ($urandom_range(0, 1) == 1) begin
        t = int'(px) + int'($urandom_range(0, 50)) - 25;
        if (t < 0) t = 0;
        if (t > W - 1) t = W - 1;
        sx = 9'(t);
        sy = 10'($urandom_range(0, 40));
      end else begin
        sx = 9'($urandom_range(0, W - 1));
        sy = 10'($urandom_range(0, H - 1));
      end
      #1;
      checks++;
      if (o_obs !== m_obst(int'(sx), int'(sy))) begin
        errors++;
        $display("FAIL random_lookup c=%0d: got %0b expected %0b", c, o_obs, m_obst(int'(sx), int'(sy)));
      end
      checks++;
      if (o_coll !== m_coll) begin
        errors++;
        $display("FAIL random_collision c=%0d: got %0b expected %0b", c, o_coll, m_coll);
      end
      checks++;
      if (o_score !== 16'(m_score)) begin
        errors++;
        $display("FAIL random_score c=%0d: got %0d expected %0d", c, o_score, m_score);
      end
      step();
    end
    tick    = 1'b0;
    restart = 1'b0;
    disp    = 1'b0;
  endtask

  initial begin
    test_reset();
    test_scroll();
    test_gap_fold();
    test_wrap();
    test_no_disp();
    test_collision();
    test_restart_tick();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
